// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared types and constants for the peripheral TX arbiter
package ui_pkg;

    localparam int ID_W           = 3;
    localparam int PAYLOAD_W      = 29;
    localparam int DEF_NUM_PERIPH = 8;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - round-robin pick of the first request strictly after the last grant
module rr_priority_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_next,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest request after i_last wins;
    // N is a power of two, so the index wraps by truncation.
    always_comb begin
        o_next = '0;
        o_any  = 1'b0;
        w_idx  = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = i_last + IDX_W'(i);
            if (i_req[w_idx]) begin
                o_next = w_idx;
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_tx_arbiter.sv
// rtl/periph_tx_arbiter.sv - round-robin burst arbiter merging peripheral FIFOs into one tagged word stream
module periph_tx_arbiter
    import ui_pkg::*;
#(
    parameter int NUM_PERIPH = DEF_NUM_PERIPH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PERIPH-1:0]                periph_valid,
    input  logic [NUM_PERIPH-1:0][PAYLOAD_W-1:0] periph_data,
    output logic [NUM_PERIPH-1:0]                periph_rd,
    output logic [ID_W+PAYLOAD_W-1:0]            data_o,
    output logic                                 periph_data_available,
    input  logic                                 read_periph_data
);

    localparam int                IDX_W     = $clog2(NUM_PERIPH);
    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_any;
    logic             w_slot_free;
    logic             w_head_valid;
    logic             w_load;

    rr_priority_select #(
        .N     (NUM_PERIPH),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req  (periph_valid),
        .i_last (r_last_grant),
        .o_next (w_next_idx),
        .o_any  (w_any)
    );

    assign w_slot_free  = !periph_data_available || read_periph_data;
    assign w_head_valid = periph_valid[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        periph_rd   = '0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_head_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_slot_free) begin
                    w_load             = 1'b1;
                    periph_rd[r_grant] = 1'b1;
                    if (r_burst_cnt == LAST_BEAT) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_grant               <= '0;
            r_last_grant          <= IDX_W'(NUM_PERIPH - 1);
            r_burst_cnt           <= '0;
            data_o                <= '0;
            periph_data_available <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_grant     <= w_next_idx;
                r_burst_cnt <= '0;
            end
            // A load takes priority over a read so a consumed word is replaced without a bubble.
            if (w_load) begin
                data_o                <= {ID_W'(r_grant), periph_data[r_grant]};
                periph_data_available <= 1'b1;
                r_burst_cnt           <= r_burst_cnt + 1'b1;
            end else if (read_periph_data) begin
                periph_data_available <= 1'b0;
            end
            if (r_state == ST_BURST && w_state_nxt == ST_IDLE) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// tb/tb_periph_tx_arbiter.sv - directed self-checking bench for periph_tx_arbiter
module tb_periph_tx_arbiter;

    localparam int N  = 8;
    localparam int MB = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         periph_valid;
    logic [N-1:0][28:0]   periph_data;
    logic [N-1:0]         periph_rd;
    logic [31:0]          data_o;
    logic                 periph_data_available;
    logic                 read_periph_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rem [N];
    int          seq [N];
    int          cyc_n;
    int          pop_idx [$];
    int          pop_cyc [$];
    logic [31:0] got [$];
    logic [31:0] d_log [$];
    logic        av_log [$];
    logic        multi_rd;

    periph_tx_arbiter #(
        .NUM_PERIPH (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .periph_valid          (periph_valid),
        .periph_data           (periph_data),
        .periph_rd             (periph_rd),
        .data_o                (data_o),
        .periph_data_available (periph_data_available),
        .read_periph_data      (read_periph_data)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] pay(input int p, input int s);
        return 29'(p * 1000 + s);
    endfunction

    function automatic logic [31:0] word(input int p, input int s);
        return {3'(p), pay(p, s)};
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            periph_valid[p] = (rem[p] > 0);
            periph_data[p]  = pay(p, seq[p]);
        end
    endtask

    task automatic clear_logs();
        pop_idx.delete(); pop_cyc.delete(); got.delete();
        d_log.delete(); av_log.delete();
        multi_rd = 1'b0;
        cyc_n    = 0;
    endtask

    task automatic cyc();
        logic [N-1:0] rd_s;
        @(negedge clk);
        rd_s = periph_rd;
        av_log.push_back(periph_data_available);
        d_log.push_back(data_o);
        if ($countones(rd_s) > 1) multi_rd = 1'b1;
        for (int p = 0; p < N; p++) begin
            if (rd_s[p]) begin
                pop_idx.push_back(p);
                pop_cyc.push_back(cyc_n);
            end
        end
        if (periph_data_available && read_periph_data) got.push_back(data_o);
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (rd_s[p]) begin
                rem[p]--;
                seq[p]++;
            end
        end
        cyc_n++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        read_periph_data = 1'b1;
        for (int p = 0; p < N; p++) begin
            rem[p] = 0;
            seq[p] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL rst_data_o got=%h exp=0", data_o); end
        n_cmp++; if (periph_data_available !== 1'b0) begin n_bad++; $display("FAIL rst_avail got=%b exp=0", periph_data_available); end
        n_cmp++; if (periph_rd !== '0) begin n_bad++; $display("FAIL rst_rd got=%b exp=0", periph_rd); end
        for (int p = 0; p < N; p++) rem[p] = 20;
        drive();
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL midrst_data_o got=%h exp=0", data_o); end
        n_cmp++; if (periph_data_available !== 1'b0) begin n_bad++; $display("FAIL midrst_avail got=%b exp=0", periph_data_available); end
        n_cmp++; if (periph_rd !== '0) begin n_bad++; $display("FAIL midrst_rd got=%b exp=0", periph_rd); end
        clear_logs();
        repeat (2) cyc();
        n_cmp++; if (pop_idx.size() !== 0) begin n_bad++; $display("FAIL rst_no_pop got=%0d exp=0", pop_idx.size()); end
        rst = 1'b0;
        clear_logs();
        repeat (3) cyc();
        n_cmp++;
        if (pop_idx.size() < 1 || pop_idx[0] !== 0) begin
            n_bad++; $display("FAIL rst_first_grant got=%0d exp=0", pop_idx.size() < 1 ? -1 : pop_idx[0]);
        end
    endtask

    task automatic test_single_source();
        int   exp_c [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
        logic exp_av;
        int   bad;
        do_reset();
        rem[3] = 10;
        drive();
        repeat (16) cyc();
        n_cmp++; if (pop_idx.size() !== 10) begin n_bad++; $display("FAIL single_pop_count got=%0d exp=10", pop_idx.size()); end
        bad = 0;
        for (int i = 0; i < 10 && i < pop_cyc.size(); i++)
            if (pop_cyc[i] !== exp_c[i] || pop_idx[i] !== 3) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_pop_timing got=%0d bad entries exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 10 && i < got.size(); i++)
            if (got[i] !== word(3, i)) bad++;
        n_cmp++; if (got.size() !== 10 || bad != 0) begin n_bad++; $display("FAIL single_words got=%0d words/%0d bad exp=10/0", got.size(), bad); end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            exp_av = 1'b0;
            foreach (exp_c[j]) if (exp_c[j] == k - 1) exp_av = 1'b1;
            if (av_log[k] !== exp_av) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_avail_pattern got=%0d bad cycles exp=0", bad); end
        n_cmp++; if (multi_rd !== 1'b0) begin n_bad++; $display("FAIL single_onehot got=%b exp=0", multi_rd); end
    endtask

    task automatic test_round_robin();
        int exp_p [4] = '{0, 2, 7, 0};
        int exp_s [4] = '{0, 0, 0, 4};
        int bad;
        do_reset();
        rem[0] = 20; rem[2] = 20; rem[7] = 20;
        drive();
        repeat (21) cyc();
        n_cmp++; if (pop_idx.size() !== 16) begin n_bad++; $display("FAIL rr_pop_count got=%0d exp=16", pop_idx.size()); end
        bad = 0;
        for (int i = 0; i < 16 && i < pop_idx.size(); i++)
            if (pop_idx[i] !== exp_p[i / 4]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rr_grant_seq got=%0d bad entries exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 16 && i < got.size(); i++)
            if (got[i] !== word(exp_p[i / 4], exp_s[i / 4] + i % 4)) bad++;
        n_cmp++; if (got.size() !== 16 || bad != 0) begin n_bad++; $display("FAIL rr_words got=%0d words/%0d bad exp=16/0", got.size(), bad); end
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int k = 2 + 5 * b; k <= 5 + 5 * b; k++)
                if (av_log[k] !== 1'b1) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rr_no_bubble got=%0d drops exp=0", bad); end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        rem[1] = 6;
        drive();
        repeat (3) cyc();
        read_periph_data = 1'b0;
        repeat (5) cyc();
        read_periph_data = 1'b1;
        repeat (10) cyc();
        bad = 0;
        for (int k = 3; k <= 7; k++) begin
            if (d_log[k] !== word(1, 1) || av_log[k] !== 1'b1) bad++;
            foreach (pop_cyc[j]) if (pop_cyc[j] == k) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_stall got=%0d bad cycles exp=0", bad); end
        n_cmp++; if (pop_idx.size() !== 6) begin n_bad++; $display("FAIL bp_pop_count got=%0d exp=6", pop_idx.size()); end
        bad = 0;
        for (int i = 0; i < 6 && i < got.size(); i++)
            if (got[i] !== word(1, i)) bad++;
        n_cmp++; if (got.size() !== 6 || bad != 0) begin n_bad++; $display("FAIL bp_words got=%0d words/%0d bad exp=6/0", got.size(), bad); end
    endtask

    task automatic test_empty_mid_burst();
        int exp_p [8] = '{5, 5, 6, 6, 6, 1, 1, 1};
        int exp_c [8] = '{1, 2, 5, 6, 7, 10, 11, 12};
        int bad;
        do_reset();
        rem[5] = 2;
        drive();
        repeat (2) cyc();
        rem[1] = 3; rem[6] = 3;
        drive();
        repeat (12) cyc();
        n_cmp++; if (pop_idx.size() !== 8) begin n_bad++; $display("FAIL empty_pop_count got=%0d exp=8", pop_idx.size()); end
        bad = 0;
        for (int i = 0; i < 8 && i < pop_idx.size(); i++)
            if (pop_idx[i] !== exp_p[i] || pop_cyc[i] !== exp_c[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL empty_grant_seq got=%0d bad entries exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 8 && i < got.size(); i++)
            if (got[i][31:29] !== 3'(exp_p[i])) bad++;
        n_cmp++; if (got.size() !== 8 || bad != 0) begin n_bad++; $display("FAIL empty_ids got=%0d words/%0d bad exp=8/0", got.size(), bad); end
    endtask

    initial begin
        rst = 1'b1;
        read_periph_data = 1'b1;
        periph_valid = '0;
        periph_data  = '0;
        clear_logs();
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_empty_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/periph_tx_arbiter.md
PERIPH_TX_ARBITER -- requirements
Module: periph_tx_arbiter

Interface
REQ-001 Parameter NUM_PERIPH, default 8, number of peripheral source channels (power of 2, 2..8).
REQ-002 Parameter MAX_BURST, default 4, max words taken from one peripheral per grant (1..15).
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 periph_valid  input  NUM_PERIPH  per-peripheral FIFO non-empty, first-word-fall-through.
REQ-006 periph_data  input  NUM_PERIPH x 29  per-peripheral head-of-FIFO payload.
REQ-007 periph_rd  output  NUM_PERIPH  one-cycle pop strobe to the granted peripheral FIFO.
REQ-008 data_o  output  32  word toward USB controller: [31:29] peripheral ID, [28:0] payload.
REQ-009 periph_data_available  output  1  data_o holds a valid word.
REQ-010 read_periph_data  input  1  USB controller consumes data_o this cycle.

Function
REQ-011 States: IDLE, BURST; shared enum in package.
REQ-012 IDLE: if any periph_valid, grant the first valid index strictly after last_grant (round-robin, wrap NUM_PERIPH-1 -> 0), clear burst_cnt, go BURST; else stay IDLE.
REQ-013 Output slot free when periph_data_available=0 or read_periph_data=1.
REQ-014 BURST load condition: periph_valid[grant]=1 and slot free; then periph_rd[grant]=1 combinationally that cycle, data_o <= {grant[2:0], periph_data[grant]}, periph_data_available <= 1, burst_cnt++ next edge.
REQ-015 periph_rd SHALL be one-hot or zero; never asserted for a non-granted index or outside BURST.
REQ-016 BURST -> IDLE, last_grant <= grant, when: load occurs with burst_cnt = MAX_BURST-1, or periph_valid[grant]=0.
REQ-017 BURST with periph_valid[grant]=1 but slot not free: hold state, grant, burst_cnt; no pop.
REQ-018 read_periph_data=1 without a same-cycle load: periph_data_available <= 0.
REQ-019 read_periph_data=1 with same-cycle load: data_o replaced, periph_data_available stays 1 (no bubble, no loss).
REQ-020 read_periph_data=1 while periph_data_available=0: ignored.
REQ-021 data_o stable while periph_data_available=1 and read_periph_data=0.
REQ-022 Latency: periph_valid rising in IDLE (cycle 0) -> grant cycle 1 -> periph_data_available=1 at cycle 2.
REQ-023 Steady throughput: 1 word/cycle within a burst while read_periph_data held high; one IDLE cycle between grants.
REQ-024 ID field = grant index zero-extended to 3 bits.

Reset
REQ-025 On rst: state IDLE, periph_data_available 0, data_o 0, periph_rd 0, burst_cnt 0, last_grant NUM_PERIPH-1 (peripheral 0 wins first).
REQ-026 rst mid-burst: output word discarded, no pop after rst assertion; resume from IDLE after release.

Structure
REQ-027 Package ui_pkg holds arb_state_t, ID_W=3, PAYLOAD_W=29, default NUM_PERIPH and MAX_BURST.
REQ-028 Sub-module rr_priority_select: combinational, inputs request vector and last_grant, outputs next index and any-request flag.
REQ-029 All state in one always_ff with async rst; next-state and periph_rd in one always_comb with full defaults.

Verification
REQ-030 Reset: rst during BURST with periph_valid=8'hFF -> all outputs zero, next grant index 0.
REQ-031 Single source: periph_valid[3]=1 for 10 words, read_periph_data=1 -> words 4,4,2 with IDLE gap, all data_o[31:29]=3, order preserved.
REQ-032 Round-robin: periph_valid=8'b1000_0101, each FIFO deep -> grant sequence 0,2,7,0,... each burst exactly 4 words.
REQ-033 Backpressure: read_periph_data=0 for 5 cycles with word pending -> data_o stable, no periph_rd, then resume with no loss or duplicate.
REQ-034 Simultaneous read+load: continuous read_periph_data=1 -> periph_data_available never drops inside a burst.
REQ-035 Source empties mid-burst: periph_valid[5] drops after 2 words -> return to IDLE, last_grant=5, next grant above 5.
